timer_regressivo: RTL
=====================

# timer_regressivo

Countdown timer that produces the three BCD digits (minutes, seconds tens, seconds ones) consumed by the `bcd_7segmentos` display decoder. The time is loaded from digit inputs, counts down once per second from a clock-derived prescaler, and can be started, paused and cancelled. It raises `done` when 0:00 is reached. It sits directly upstream of the decoder; its `mins`, `sec_tens` and `sec_ones` outputs connect to the decoder inputs of the same names.

## Interface

- `TICKS_PER_SEC`, default 100, number of `clk` cycles per one-second decrement (≥2; 4 in bench).
- `clk` input 1: single system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `load` input 1: capture `load_mins`/`load_sec_tens`/`load_sec_ones`.
- `load_mins` input 4: BCD minutes to load (0–9).
- `load_sec_tens` input 4: BCD seconds tens to load (0–5).
- `load_sec_ones` input 4: BCD seconds ones to load (0–9).
- `start` input 1: begin or resume counting.
- `stop` input 1: pause when running; cancel when paused or done.
- `mins` output 4: current minutes digit, BCD.
- `sec_tens` output 4: current seconds tens digit, BCD.
- `sec_ones` output 4: current seconds ones digit, BCD.
- `running` output 1: high in RUNNING.
- `done` output 1: high in DONE.

## Operation

- States: IDLE, RUNNING, PAUSED, DONE. All outputs are registered.
- Control inputs are level-sampled every cycle. Priority is `reset` > `load` > `stop` > `start`.
- Load is accepted in IDLE, PAUSED and DONE.
  - The state goes to IDLE and the prescaler clears.
  - Out-of-range digits saturate: `load_mins`>9→9, `load_sec_tens`>5→5, `load_sec_ones`>9→9.
  - Load is ignored in RUNNING.
- Start behaviour:
  - In IDLE or PAUSED with time ≠ 0:00, start moves to RUNNING.
  - Start with time = 0:00 is ignored.
  - Start in RUNNING or DONE has no effect.
- Stop behaviour:
  - RUNNING→PAUSED; digits and prescaler are held.
  - PAUSED→IDLE with digits cleared to 0:00.
  - DONE→IDLE with digits held at 0:00.
  - Stop in IDLE has no effect.
- Prescaler:
  - Counter width is $clog2(TICKS_PER_SEC).
  - It increments only in RUNNING and is held in PAUSED.
  - It clears in IDLE, DONE and on load.
  - A tick fires in the cycle the counter equals TICKS_PER_SEC−1; the counter wraps to 0 in that cycle.
- Decrement on tick, with borrow chain:
  - If `sec_ones`≠0, decrement `sec_ones`.
  - Else set `sec_ones`=9 and borrow from `sec_tens`.
  - If `sec_tens`≠0, decrement `sec_tens`; else set `sec_tens`=5 and borrow from `mins`.
  - Decrement `mins`.
- If the decrement result is 0:00, the state goes to DONE in the same edge. Digits never wrap below 0:00.
- Pause and resume keep the partial second, so the total RUNNING cycles per second stay exactly TICKS_PER_SEC.

## Timing

- Reset:
  - Applied at the next rising edge; overrides everything, including mid-count.
  - Reset values: all digits 0, `running`=0, `done`=0, state IDLE, prescaler 0.
- Load latency: digits update on the edge that samples `load`=1.
- Start latency: `running` goes high on the edge that samples `start`.
  - The first decrement occurs TICKS_PER_SEC cycles after that edge when the prescaler starts from 0.
- Decrement: digits change on the same edge as the tick.
- Done:
  - On the final tick, `running` falls and `done` rises on the same edge that digits become 0:00.
  - `done` stays high until `stop`, `load` or `reset`.
- Pause: `running` falls on the edge sampling `stop`. No decrement occurs on that edge, even if a tick coincided (stop wins).
- Simultaneous `start`+`stop`: stop action only.

## Test plan

1. Reset, then load 1:05 and start (TICKS_PER_SEC=4):
   - The first decrement to 1:04 lands 4 cycles after the start edge.
   - The sequence is 1:04, 1:03, …, 1:00, 0:59, 0:58 with 4 cycles per step.
2. Load 0:10 and start:
   - Expect 0:09 … 0:01, 0:00.
   - At 0:00, `done`=1 and `running`=0 on the same edge.
   - Digits stay 0:00 for 20 more cycles.
   - Then stop gives IDLE with `done`=0.
3. Load 9:59 and start; pause after 2 cycles and hold for 10 cycles; then start:
   - Digits are held during the pause.
   - 9:58 appears exactly 4 RUNNING cycles after the original start.
4. Load with saturating values:
   - `load_mins`=12, `load_sec_tens`=7, `load_sec_ones`=15 → 9:59.
   - Load 0:00 then start → stays IDLE, `running`=0.
5. Running 3:27:
   - `load` asserted → ignored.
   - `stop` → PAUSED.
   - `stop` again → IDLE at 0:00.
   - `start`+`stop` together while RUNNING → PAUSED only.
6. Mid-count reset at 4:13 while RUNNING → next edge gives 0:00, `running`=0, `done`=0; the first decrement after a new load 0:02 and start again takes 4 cycles.

Source files
------------

// File: rtl/timer_regressivo.sv
// timer_regressivo: BCD m:ss countdown timer with load, start, pause/cancel and done flag
module timer_regressivo #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_mins,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);
  localparam int W = $clog2(TICKS_PER_SEC);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] presc, presc_n;
  logic [3:0] mins_n, tens_n, ones_n, dec_m, dec_t, dec_o;
  logic tick, zero, load_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      mins     <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      mins     <= mins_n;
      sec_tens <= tens_n;
      sec_ones <= ones_n;
      running  <= state_n == RUNNING;
      done     <= state_n == DONE;
    end
  end
  always_comb begin
    tick    = presc == W'(TICKS_PER_SEC - 1);
    dec_o   = sec_ones == 4'd0 ? 4'd9 : sec_ones - 4'd1;
    dec_t   = sec_ones != 4'd0 ? sec_tens : sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1;
    dec_m   = (sec_ones == 4'd0 && sec_tens == 4'd0) ? mins - 4'd1 : mins;
    zero    = {dec_m, dec_t, dec_o} == 12'd0;
    load_ok = load && state != RUNNING;
    state_n = state;
    presc_n = presc;
    mins_n  = mins;
    tens_n  = sec_tens;
    ones_n  = sec_ones;
    if (load_ok) begin
      state_n = IDLE;
      presc_n = '0;
      mins_n  = load_mins > 4'd9 ? 4'd9 : load_mins;
      tens_n  = load_sec_tens > 4'd5 ? 4'd5 : load_sec_tens;
      ones_n  = load_sec_ones > 4'd9 ? 4'd9 : load_sec_ones;
    end else if (stop) begin
      state_n = state == RUNNING ? PAUSED : IDLE;
      presc_n = state == RUNNING ? presc : '0;
      mins_n  = state == PAUSED ? 4'd0 : mins;
      tens_n  = state == PAUSED ? 4'd0 : sec_tens;
      ones_n  = state == PAUSED ? 4'd0 : sec_ones;
    end else if (start && (state == IDLE || state == PAUSED) && {mins, sec_tens, sec_ones} != 12'd0) begin
      state_n = RUNNING;
    end else if (state == RUNNING) begin
      presc_n = tick ? '0 : presc + W'(1);
      mins_n  = tick ? dec_m : mins;
      tens_n  = tick ? dec_t : sec_tens;
      ones_n  = tick ? dec_o : sec_ones;
      state_n = (tick && zero) ? DONE : RUNNING;
    end
  end
endmodule
